prefix_sum_stage: RTL and testbench

PREFIX_SUM_STAGE -- requirements
Module: prefix_sum_stage

---
 rtl/prefix_sum_stage_pkg.sv | 13 +
 rtl/prefix_sum_stage_carry_resolve.sv | 31 +++
 rtl/prefix_sum_stage.sv | 98 +++++++++
 tb/tb_prefix_sum_stage.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefix_sum_stage_pkg.sv
// Shared constants and helpers for the parallel-prefix adder stages.
package prefix_sum_stage_pkg;

  localparam int ADDER_WIDTH = 7;
  localparam int CNT_WIDTH   = 8;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = 8'd255;

  // The delivered-result counter sticks at CNT_MAX instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
    return (value == CNT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/prefix_sum_stage_carry_resolve.sv
// Final carry resolution of a prefix adder: folds cin into the group terms and
// forms sum, unsigned carry-out and signed overflow.
module carry_resolve
  import prefix_sum_stage_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic [WIDTH-1:0] half_sum,
  input  logic [WIDTH-1:0] grp_generate,
  input  logic [WIDTH-1:0] grp_propagate,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH:0] carry;

  always_comb begin
    carry    = '0;
    carry[0] = cin;
    for (int i = 1; i <= WIDTH; i++) begin
      carry[i] = grp_generate[i-1] | (grp_propagate[i-1] & cin);
    end
  end

  assign sum  = half_sum ^ carry[WIDTH-1:0];
  assign cout = carry[WIDTH];
  assign ovf  = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

// File: rtl/prefix_sum_stage.sv
// Two-stage valid/ready pipeline closing a prefix adder: stage 1 holds the
// prefix vectors, stage 2 holds the resolved sum, carry-out and overflow.
module prefix_sum_stage
  import prefix_sum_stage_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     half_sum,
  input  logic [WIDTH-1:0]     grp_generate,
  input  logic [WIDTH-1:0]     grp_propagate,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     sum,
  output logic                 cout,
  output logic                 ovf,
  output logic [CNT_WIDTH-1:0] result_cnt
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_half;
  logic [WIDTH-1:0] s1_gen;
  logic [WIDTH-1:0] s1_prop;
  logic             s1_cin;
  logic             s2_valid;
  logic             s1_load;
  logic             s2_load;

  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_ovf;

  // An empty stage 2 always loads, so bubbles collapse even under backpressure.
  assign s2_load   = !s2_valid | out_ready;
  assign s1_load   = !s1_valid | s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  carry_resolve #(
    .WIDTH(WIDTH)
  ) u_carry_resolve (
    .half_sum      (s1_half),
    .grp_generate  (s1_gen),
    .grp_propagate (s1_prop),
    .cin           (s1_cin),
    .sum           (res_sum),
    .cout          (res_cout),
    .ovf           (res_ovf)
  );

  // Data is captured only with in_valid, so idle or X inputs never reach state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_half  <= '0;
      s1_gen   <= '0;
      s1_prop  <= '0;
      s1_cin   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_half <= half_sum;
        s1_gen  <= grp_generate;
        s1_prop <= grp_propagate;
        s1_cin  <= cin;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sum  <= res_sum;
        cout <= res_cout;
        ovf  <= res_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_cnt <= '0;
    end else if (s2_valid && out_ready) begin
      result_cnt <= sat_inc(result_cnt);
    end
  end

endmodule

// File: tb/tb_prefix_sum_stage.sv
// Self-checking bench for prefix_sum_stage: operands a/b are expanded into
// prefix vectors and results are predicted from plain integer addition.
module tb_prefix_sum_stage;
  import prefix_sum_stage_pkg::*;

  localparam int W = ADDER_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] half_sum = '0;
  logic [W-1:0] grp_generate = '0;
  logic [W-1:0] grp_propagate = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [7:0]   result_cnt;

  int total = 0;
  int bad = 0;
  int delivered = 0;
  logic [W+1:0] exp_q[$];

  always #5 clk = ~clk;

  prefix_sum_stage #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .half_sum      (half_sum),
    .grp_generate  (grp_generate),
    .grp_propagate (grp_propagate),
    .cin           (cin),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .sum           (sum),
    .cout          (cout),
    .ovf           (ovf),
    .result_cnt    (result_cnt)
  );

  // Reference result {cout, ovf, sum} from integer addition of the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    int full;
    logic [W-1:0] s;
    logic v;
    full = int'(a) + int'(b) + int'(c);
    s = full[W-1:0];
    v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {full[W], v, s};
  endfunction

  // Upstream prefix network: operands to half-sum, group generate, group propagate.
  task automatic make_vectors(input logic [W-1:0] a, input logic [W-1:0] b,
                              output logic [W-1:0] hs, output logic [W-1:0] gg,
                              output logic [W-1:0] pp);
    logic [W-1:0] g;
    hs = a ^ b;
    g = a & b;
    gg[0] = g[0];
    pp[0] = hs[0];
    for (int i = 1; i < W; i++) begin
      gg[i] = g[i] | (hs[i] & gg[i-1]);
      pp[i] = hs[i] & pp[i-1];
    end
  endtask

  // Drives one cycle, records handshakes and pops the scoreboard; no checking here.
  task automatic run_cycle(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input bit r, output bit in_hs, output bit out_hs,
                           output logic [W+1:0] got, output logic [W+1:0] want,
                           output logic [7:0] cnt_seen, output int cnt_want);
    logic [W-1:0] hs, gg, pp;
    if (v) begin
      make_vectors(a, b, hs, gg, pp);
      half_sum = hs;
      grp_generate = gg;
      grp_propagate = pp;
      cin = c;
    end else begin
      half_sum = 'x;
      grp_generate = 'x;
      grp_propagate = 'x;
      cin = 1'bx;
    end
    in_valid = v;
    out_ready = r;
    @(negedge clk);
    in_hs = v && in_ready;
    out_hs = out_valid && r;
    got = {cout, ovf, sum};
    cnt_seen = result_cnt;
    cnt_want = (delivered > 255) ? 255 : delivered;
    want = 'x;
    if (out_hs) begin
      if (exp_q.size() > 0) want = exp_q.pop_front();
      delivered++;
    end
    if (in_hs) exp_q.push_back(model(a, b, c));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if (result_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_cnt: got %0d want 0", result_cnt); end
    total++;
    if ({cout, ovf, sum} !== '0) begin bad++; $display("[TB] FAIL reset_data: got %h want 0", {cout, ovf, sum}); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    exp_q.delete();
    delivered = 0;
  endtask

  task automatic test_directed();
    logic [W-1:0] t_hs[3] = '{7'h3F, 7'h7E, 7'h3E};
    logic [W-1:0] t_g[3]  = '{7'h00, 7'h7F, 7'h3F};
    logic [W-1:0] t_p[3]  = '{7'h3F, 7'h00, 7'h00};
    logic [W+1:0] t_exp[3] = '{{1'b0, 1'b0, 7'h3F}, {1'b1, 1'b0, 7'h00}, {1'b0, 1'b1, 7'h40}};
    for (int k = 0; k < 3; k++) begin
      out_ready = 1'b1;
      in_valid = 1'b1;
      half_sum = t_hs[k];
      grp_generate = t_g[k];
      grp_propagate = t_p[k];
      cin = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      half_sum = 'x;
      grp_generate = 'x;
      grp_propagate = 'x;
      cin = 1'bx;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL directed%0d_early: got %b want 0", k, out_valid); end
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL directed%0d_valid: got %b want 1", k, out_valid); end
      total++;
      if ({cout, ovf, sum} !== t_exp[k])
        begin bad++; $display("[TB] FAIL directed%0d_data: got %h want %h", k, {cout, ovf, sum}, t_exp[k]); end
      @(posedge clk);
      #1;
      delivered++;
    end
  endtask

  task automatic test_back_to_back();
    bit ih, oh;
    logic [W+1:0] got, want;
    logic [7:0] cs;
    int cw;
    for (int k = 0; k < 32; k++) begin
      if (k < 30)
        run_cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1, ih, oh, got, want, cs, cw);
      else
        run_cycle(1'b0, '0, '0, 1'b0, 1'b1, ih, oh, got, want, cs, cw);
      if (k < 30) begin
        total++;
        if (ih !== 1'b1) begin bad++; $display("[TB] FAIL b2b_in_ready cycle %0d: got %b want 1", k, ih); end
      end
      if (k >= 2) begin
        total++;
        if (oh !== 1'b1) begin bad++; $display("[TB] FAIL b2b_bubble cycle %0d: got %b want 1", k, oh); end
        total++;
        if (got !== want) begin bad++; $display("[TB] FAIL b2b_data cycle %0d: got %h want %h", k, got, want); end
      end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL b2b_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ta[4], tb[4];
    logic tc[4];
    int idx = 0;
    int rcv = 0;
    bit have_hold = 0;
    logic [W+1:0] hold;
    bit ih, oh;
    logic [W+1:0] got, want;
    logic [7:0] cs;
    int cw;
    for (int k = 0; k < 4; k++) begin
      ta[k] = W'($urandom);
      tb[k] = W'($urandom);
      tc[k] = 1'($urandom);
    end
    for (int k = 0; k < 5; k++) begin
      run_cycle(idx < 4, ta[idx % 4], tb[idx % 4], tc[idx % 4], 1'b0, ih, oh, got, want, cs, cw);
      if (ih) idx++;
      if (out_valid) begin
        if (have_hold) begin
          total++;
          if ({cout, ovf, sum} !== hold)
            begin bad++; $display("[TB] FAIL bp_hold: got %h want %h", {cout, ovf, sum}, hold); end
        end
        hold = {cout, ovf, sum};
        have_hold = 1;
      end
    end
    total++;
    if (idx != 2) begin bad++; $display("[TB] FAIL bp_accepts: got %0d want 2", idx); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready: got %b want 0", in_ready); end
    for (int k = 0; k < 20 && rcv < 4; k++) begin
      run_cycle(idx < 4, ta[idx % 4], tb[idx % 4], tc[idx % 4], 1'b1, ih, oh, got, want, cs, cw);
      if (ih) idx++;
      if (oh) begin
        total++;
        if (got !== model(ta[rcv], tb[rcv], tc[rcv]))
          begin bad++; $display("[TB] FAIL bp_order result %0d: got %h want %h", rcv, got, model(ta[rcv], tb[rcv], tc[rcv])); end
        rcv++;
      end
    end
    total++;
    if (rcv != 4) begin bad++; $display("[TB] FAIL bp_count: got %0d want 4", rcv); end
    exp_q.delete();
  endtask

  task automatic test_random();
    bit ih, oh;
    logic [W+1:0] got, want;
    logic [7:0] cs;
    int cw;
    for (int k = 0; k < 300 || (exp_q.size() > 0 && k < 320); k++) begin
      run_cycle(k < 300 && $urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 1'($urandom),
                k >= 300 || $urandom_range(0, 2) != 0, ih, oh, got, want, cs, cw);
      if (oh) begin
        total++;
        if (got !== want) begin bad++; $display("[TB] FAIL rand_data cycle %0d: got %h want %h", k, got, want); end
      end
      total++;
      if (cs !== 8'(cw)) begin bad++; $display("[TB] FAIL rand_cnt cycle %0d: got %0d want %0d", k, cs, cw); end
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL rand_lost: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    bit ih, oh;
    logic [W+1:0] got, want;
    logic [7:0] cs;
    int cw;
    for (int k = 0; k < 2; k++)
      run_cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0, ih, oh, got, want, cs, cw);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_full: got in_ready %b want 0", in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_out_valid: got %b want 0", out_valid); end
    total++;
    if (result_cnt !== 8'd0) begin bad++; $display("[TB] FAIL mid_cnt: got %0d want 0", result_cnt); end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    delivered = 0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      run_cycle(1'b0, '0, '0, 1'b0, 1'b1, ih, oh, got, want, cs, cw);
      total++;
      if (oh !== 1'b0) begin bad++; $display("[TB] FAIL mid_stale cycle %0d: got %b want 0", k, oh); end
    end
  endtask

  task automatic test_saturation();
    int sent = 0;
    bit ih, oh;
    logic [W+1:0] got, want;
    logic [7:0] cs;
    int cw;
    for (int k = 0; k < 400 && delivered < 260; k++) begin
      run_cycle(sent < 260, W'($urandom), W'($urandom), 1'($urandom), 1'b1, ih, oh, got, want, cs, cw);
      if (ih) sent++;
      if (oh) begin
        total++;
        if (got !== want) begin bad++; $display("[TB] FAIL sat_data cycle %0d: got %h want %h", k, got, want); end
      end
      total++;
      if (cs !== 8'(cw)) begin bad++; $display("[TB] FAIL sat_cnt cycle %0d: got %0d want %0d", k, cs, cw); end
    end
    total++;
    if (delivered < 260) begin bad++; $display("[TB] FAIL sat_timeout: got %0d handshakes want 260", delivered); end
    total++;
    if (result_cnt !== 8'd255) begin bad++; $display("[TB] FAIL sat_final: got %0d want 255", result_cnt); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
